// File: rtl/register_slice_pkg.sv
// Shared types and constants for the valid/ready register slice.
package register_slice_pkg;

    // Encoding equals the number of held entries, so occupancy decodes trivially.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage : register_slice_pkg

// File: rtl/register_slice_ctrl.sv
// Control FSM of the register slice: tracks occupancy, registers the
// upstream ready and produces load enables for the main/skid data registers.
module register_slice_ctrl
    import register_slice_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic       m_ready,
    input  logic       flush,
    output logic       s_ready,
    output logic       m_valid,
    output logic [1:0] occupancy,
    output logic       load_main,
    output logic       sel_skid,
    output logic       load_skid
);

    state_t state_q, state_d;
    logic   ready_q, ready_d;
    logic   s_hs, m_hs;

    // Ready is a flop so the backpressure path is cut; FLUSH only gates it.
    assign s_ready = ready_q & ~flush;
    assign m_valid = (state_q != EMPTY);
    assign s_hs    = s_valid & s_ready;
    assign m_hs    = m_valid & m_ready;

    // Next-state and load-enable decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        load_main = 1'b0;
        sel_skid  = 1'b0;
        load_skid = 1'b0;
        if (flush) begin
            // A concurrent m_hs still completes; everything else is discarded.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (s_hs) begin
                        state_d   = BUSY;
                        load_main = 1'b1;
                    end
                end
                BUSY: begin
                    if (s_hs && !m_hs) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (!s_hs && m_hs) begin
                        state_d = EMPTY;
                    end else if (s_hs && m_hs) begin
                        load_main = 1'b1;
                    end
                end
                FULL: begin
                    if (m_hs) begin
                        state_d   = BUSY;
                        load_main = 1'b1;
                        sel_skid  = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        ready_d = (state_d != FULL);
    end

    // State and registered-ready flops.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // Occupancy readout decoded from the state flop only.
    always_comb begin
        occupancy = OCC_EMPTY;
        unique case (state_q)
            BUSY:    occupancy = OCC_ONE;
            FULL:    occupancy = OCC_TWO;
            default: occupancy = OCC_EMPTY;
        endcase
    end

endmodule : register_slice_ctrl

// File: rtl/register_slice.sv
// Full-throughput register slice: main + skid data registers, flush support
// and a saturating count of entries discarded by flush.
module register_slice
    import register_slice_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      S_VALID,
    output logic                      S_READY,
    input  logic [DATA_WIDTH-1:0]     S_DATA,
    output logic                      M_VALID,
    input  logic                      M_READY,
    output logic [DATA_WIDTH-1:0]     M_DATA,
    input  logic                      FLUSH,
    output logic [1:0]                OCCUPANCY,
    output logic [DROP_CNT_WIDTH-1:0] DROP_COUNT
);

    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};

    logic                      load_main, sel_skid, load_skid;
    logic                      m_hs;
    logic [1:0]                dropped;
    logic [DROP_CNT_WIDTH:0]   drop_sum;
    logic [DATA_WIDTH-1:0]     main_q, main_d;
    logic [DATA_WIDTH-1:0]     skid_q, skid_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

    register_slice_ctrl u_ctrl (
        .clk       (CLK),
        .rst       (RST),
        .s_valid   (S_VALID),
        .m_ready   (M_READY),
        .flush     (FLUSH),
        .s_ready   (S_READY),
        .m_valid   (M_VALID),
        .occupancy (OCCUPANCY),
        .load_main (load_main),
        .sel_skid  (sel_skid),
        .load_skid (load_skid)
    );

    assign m_hs       = M_VALID & M_READY;
    assign M_DATA     = main_q;
    assign DROP_COUNT = drop_q;

    // Data register next values: main refills from skid when draining FULL.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (load_main) main_d = sel_skid ? skid_q : S_DATA;
        if (load_skid) skid_d = S_DATA;
    end

    // Saturating drop counter: entries held minus the one delivered this cycle.
    always_comb begin
        dropped  = OCCUPANCY - {1'b0, m_hs};
        drop_sum = {1'b0, drop_q} + (DROP_CNT_WIDTH+1)'(dropped);
        drop_d   = drop_q;
        if (FLUSH) drop_d = drop_sum[DROP_CNT_WIDTH] ? DROP_MAX : drop_sum[DROP_CNT_WIDTH-1:0];
    end

    // Data and counter flops.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: the data registers are reset too, so M_DATA reads a defined zero out of reset.
        if (RST) begin
            main_q <= '0;
            skid_q <= '0;
            drop_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            drop_q <= drop_d;
        end
    end

endmodule : register_slice
